// File: rtl/riscv_pkg.sv
// Shared RV32I core constants and the IF/ID pipeline register payload.
// The same constants are used by the decode-stage bubble logic.
package riscv_pkg;

   localparam int XLEN = 32;

   // addi x0,x0,0: the canonical bubble instruction
   localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic            valid;
   } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: hold when disabled, synchronous clear to a bubble
// (clear wins over hold), asynchronous reset to the same bubble.
module if_id_reg
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   en,
   input  logic   clr,
   input  if_id_t d,
   output if_id_t q
);

   localparam if_id_t BUBBLE = '{inst: NOP_INST, pc: '0, pc_plus4: '0, valid: 1'b0};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= BUBBLE;
      end else if (clr) begin
         q <= BUBBLE;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register with redirect/stall priority, sticky
// misaligned-redirect flag, and the IF/ID register fed from instruction memory.
module fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
   parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_f,
   input  logic            stall_d,
   input  logic            flush_d,
   input  logic            pc_src_e,
   input  logic [XLEN-1:0] pc_target_e,
   input  logic [XLEN-1:0] inst_f,
   output logic [XLEN-1:0] pc_f,
   output logic [XLEN-1:0] inst_d,
   output logic [XLEN-1:0] pc_d,
   output logic [XLEN-1:0] pc_plus4_d,
   output logic            valid_d,
   output logic            misalign_err
);

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] pc_next;
   logic            misalign;
   if_id_t          if_id_next;
   if_id_t          if_id_q;

   assign pc_plus4 = pc + 32'd4;

   // A redirect beats a stall so a taken branch is never dropped.
   always_comb begin
      pc_next = pc_plus4;
      if (pc_src_e) begin
         pc_next = {pc_target_e[XLEN-1:2], 2'b00};
      end else if (stall_f) begin
         pc_next = pc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= RESET_PC;
         misalign <= 1'b0;
      end else begin
         pc <= pc_next;
         if (pc_src_e && (pc_target_e[1:0] != 2'b00)) begin
            misalign <= 1'b1;
         end
      end
   end

   assign if_id_next = '{inst: inst_f, pc: pc, pc_plus4: pc_plus4, valid: 1'b1};

   if_id_reg #(
      .NOP_INST (NOP_INST)
   ) u_if_id (
      .clk (clk),
      .rst (rst),
      .en  (~stall_d),
      .clr (flush_d),
      .d   (if_id_next),
      .q   (if_id_q)
   );

   assign pc_f         = pc;
   assign inst_d       = if_id_q.inst;
   assign pc_d         = if_id_q.pc;
   assign pc_plus4_d   = if_id_q.pc_plus4;
   assign valid_d      = if_id_q.valid;
   assign misalign_err = misalign;

endmodule
